// File: rtl/nor3_chk_pkg.sv
// Shared definitions for the 3-input gate truth-table checker.
//   - state_t       : FSM state encoding (IDLE/SETTLE/SAMPLE/DONE)
//   - NUM_VECTORS   : number of input combinations swept
//   - NOR3/OR3/...  : ready-made expected truth tables, bit index = {A,B,C}
//   - table_diff()  : per-vector mismatch mask between observed and expected
package nor3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  localparam logic [NUM_VECTORS-1:0] NOR3  = 8'h01;
  localparam logic [NUM_VECTORS-1:0] OR3   = 8'hFE;
  localparam logic [NUM_VECTORS-1:0] AND3  = 8'h80;
  localparam logic [NUM_VECTORS-1:0] NAND3 = 8'h7F;

  // Bit k set means vector k produced the wrong output.
  function automatic logic [NUM_VECTORS-1:0] table_diff(
    input logic [NUM_VECTORS-1:0] observed,
    input logic [NUM_VECTORS-1:0] expected
  );
    return observed ^ expected;
  endfunction

endpackage

// File: rtl/nor3_truth_table_checker_settle_timer.sv
// Settle interval timer.
// Counts cycles while en is high; clear forces the count back to zero and
// takes priority over en. tc flags the last settle cycle (count == S-1), so
// the caller can clear on tc and the count never exceeds SETTLE_CYCLES-1.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : return count to zero next cycle
//   en       : advance count by one
//   count    : current count, $clog2(SETTLE_CYCLES+1) bits
//   tc       : terminal count, only asserted while en is high
module settle_timer
  import nor3_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CW            = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/nor3_truth_table_checker.sv
// Sequential truth-table checker for a 3-input gate.
// Sweeps {A,B,C} through 0..7, holds each vector for SETTLE_CYCLES cycles,
// samples the gate output for one cycle, then compares the observed table
// against EXPECT.
// Handshake: start is a level sampled only in IDLE or DONE; a rising busy
// acknowledges it. Results (pass, fail_mask) are valid while done is high and
// stay valid until the next accepted start or rst.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a sweep (ignored while busy)
//   a_out/b_out/c_out : gate inputs, {a,b,c} = vec_idx
//   d_in              : gate output under test
//   busy, done        : sweep running / sweep finished (sticky)
//   pass, fail_mask   : comparison result, valid with done
//   vec_idx           : vector currently driven
//   fsm_state         : FSM state for observation
module nor3_truth_table_checker
  import nor3_chk_pkg::*;
#(
  parameter int unsigned             SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0]  EXPECT        = NOR3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   a_out,
  output logic                   b_out,
  output logic                   c_out,
  input  logic                   d_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_mask,
  output logic [VEC_W-1:0]       vec_idx,
  output state_t                 fsm_state
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  state_t                 state;
  state_t                 state_n;
  logic [NUM_VECTORS-1:0] obs;
  logic [CW-1:0]          cnt;
  logic                   cnt_tc;
  logic                   cnt_clear;
  logic                   cnt_en;
  logic                   accept_start;

  // Start only counts when no sweep is running.
  assign accept_start = start && ((state == IDLE) || (state == DONE));

  // Counter runs only in SETTLE and restarts from zero on every other cycle,
  // including the last settle cycle, so each vector gets a fresh interval.
  assign cnt_en    = (state == SETTLE);
  assign cnt_clear = (state != SETTLE) || cnt_tc;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CW            (CW)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept_start) state_n = SETTLE;
      SETTLE:  if (cnt_tc)       state_n = SAMPLE;
      SAMPLE:  state_n = (vec_idx == LAST_VEC) ? DONE : SETTLE;
      DONE:    if (accept_start) state_n = SETTLE;
      default: state_n = IDLE;
    endcase
  end

  // Vector index and observed table. The index stops at 7 so DONE keeps
  // driving the last vector; only a restart brings it back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx <= '0;
      obs     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_start) begin
            vec_idx <= '0;
            obs     <= '0;
          end
        end
        SAMPLE: begin
          obs[vec_idx] <= d_in;
          if (vec_idx != LAST_VEC) begin
            vec_idx <= vec_idx + 1'b1;
          end
        end
        default: begin
          vec_idx <= vec_idx;
          obs     <= obs;
        end
      endcase
    end
  end

  // Outputs. In DONE obs already includes vector 7 (written on the
  // SAMPLE->DONE edge), and results drop as soon as a restart leaves DONE.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    fail_mask = '0;
    case (state)
      SETTLE, SAMPLE: busy = 1'b1;
      DONE: begin
        done      = 1'b1;
        pass      = (obs == EXPECT);
        fail_mask = table_diff(obs, EXPECT);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign a_out     = vec_idx[2];
  assign b_out     = vec_idx[1];
  assign c_out     = vec_idx[0];
  assign fsm_state = state;

endmodule

// File: tb/tb_nor3_truth_table_checker.sv
// Bench for nor3_truth_table_checker: three instances (S=2/NOR3, S=2/OR3,
// S=1/NOR3) share one gate model selected by gate_mode.
module tb_nor3_truth_table_checker;
  import nor3_chk_pkg::*;

  localparam int MODE_NOR  = 0;
  localparam int MODE_ZERO = 1;
  localparam int MODE_OR   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int gate_mode = MODE_NOR;

  logic [2:0]      start_v = '0;
  logic [2:0]      a_v, b_v, c_v, d_v, busy_v, done_v, pass_v;
  logic [2:0][7:0] mask_v;
  logic [2:0][2:0] idx_v;
  state_t          st_v [3];

  function automatic logic gate(input int mode, input logic a, input logic b, input logic c);
    case (mode)
      MODE_NOR:  return ~(a | b | c);
      MODE_OR:   return a | b | c;
      default:   return 1'b0;
    endcase
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_gate
    assign d_v[i] = gate(gate_mode, a_v[i], b_v[i], c_v[i]);
  end

  nor3_truth_table_checker #(.SETTLE_CYCLES(2), .EXPECT(NOR3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
    .c_out(c_v[0]), .d_in(d_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail_mask(mask_v[0]), .vec_idx(idx_v[0]), .fsm_state(st_v[0])
  );

  nor3_truth_table_checker #(.SETTLE_CYCLES(2), .EXPECT(OR3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
    .c_out(c_v[1]), .d_in(d_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail_mask(mask_v[1]), .vec_idx(idx_v[1]), .fsm_state(st_v[1])
  );

  nor3_truth_table_checker #(.SETTLE_CYCLES(1), .EXPECT(NOR3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
    .c_out(c_v[2]), .d_in(d_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .fail_mask(mask_v[2]), .vec_idx(idx_v[2]), .fsm_state(st_v[2])
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on instance d (cycle 0 = the cycle start is high) and
  // follow it to done. Vector k must appear at cycle 1+k(s+1); done at
  // cycle 1+8(s+1). glitch re-pulses start at cycles 5 and 12.
  task automatic run_sweep(input int d, input int s, input logic ep,
                           input logic [7:0] em, input bit glitch, input string tag);
    int  c;
    bit  seen;
    int  k;
    tick();
    start_v[d] = 1'b1;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 100) begin
      tick();
      c++;
      start_v[d] = glitch && (c == 5 || c == 12);
      if (c == 1) begin
        check({tag, " restart done clear"}, 32'(done_v[d]), 32'd0);
        check({tag, " restart pass clear"}, 32'(pass_v[d]), 32'd0);
        check({tag, " restart mask clear"}, 32'(mask_v[d]), 32'd0);
      end
      if (c <= 8 * (s + 1) && ((c - 1) % (s + 1)) == 0) begin
        k = (c - 1) / (s + 1);
        check($sformatf("%s vec_idx@%0d", tag, c), 32'(idx_v[d]), 32'(k));
        check($sformatf("%s abc@%0d", tag, c), 32'({a_v[d], b_v[d], c_v[d]}), 32'(k));
        check($sformatf("%s busy@%0d", tag, c), 32'(busy_v[d]), 32'd1);
      end
      if (done_v[d]) seen = 1'b1;
    end
    start_v[d] = 1'b0;
    check({tag, " done cycle"}, 32'(c), 32'(8 * (s + 1) + 1));
    check({tag, " pass"}, 32'(pass_v[d]), 32'(ep));
    check({tag, " fail_mask"}, 32'(mask_v[d]), 32'(em));
    check({tag, " busy at done"}, 32'(busy_v[d]), 32'd0);
    check({tag, " abc hold 7"}, 32'({a_v[d], b_v[d], c_v[d]}), 32'd7);
  endtask

  typedef struct {
    int         dut;
    int         s;
    int         mode;
    logic       ep;
    logic [7:0] em;
  } sweep_t;

  sweep_t tbl [7];

  initial begin
    tbl[0] = '{dut: 0, s: 2, mode: MODE_NOR,  ep: 1'b1, em: 8'h00};
    tbl[1] = '{dut: 0, s: 2, mode: MODE_ZERO, ep: 1'b0, em: 8'h01};
    tbl[2] = '{dut: 0, s: 2, mode: MODE_OR,   ep: 1'b0, em: 8'hFF};
    tbl[3] = '{dut: 1, s: 2, mode: MODE_OR,   ep: 1'b1, em: 8'h00};
    tbl[4] = '{dut: 1, s: 2, mode: MODE_NOR,  ep: 1'b0, em: 8'hFF};
    tbl[5] = '{dut: 2, s: 1, mode: MODE_NOR,  ep: 1'b1, em: 8'h00};
    tbl[6] = '{dut: 2, s: 1, mode: MODE_ZERO, ep: 1'b0, em: 8'h01};

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("reset state", 32'(st_v[0]), 32'(IDLE));
    check("reset busy", 32'(busy_v[0]), 32'd0);
    check("reset done", 32'(done_v[0]), 32'd0);
    check("reset pass", 32'(pass_v[0]), 32'd0);
    check("reset mask", 32'(mask_v[0]), 32'd0);
    check("reset abc", 32'({a_v[0], b_v[0], c_v[0]}), 32'd0);
    check("reset vec_idx", 32'(idx_v[0]), 32'd0);
    rst = 1'b0;
    tick();

    // table-driven sweeps (each one also restarts from DONE)
    for (int i = 0; i < 7; i++) begin
      gate_mode = tbl[i].mode;
      run_sweep(tbl[i].dut, tbl[i].s, tbl[i].ep, tbl[i].em, 1'b0, $sformatf("tbl%0d", i));
    end

    // done/pass are sticky in DONE
    gate_mode = MODE_NOR;
    repeat (4) tick();
    check("sticky done", 32'(done_v[2]), 32'd1);
    check("sticky mask", 32'(mask_v[2]), 32'h01);

    // start pulses mid-sweep are ignored
    run_sweep(0, 2, 1'b1, 8'h00, 1'b1, "glitch");

    // reset mid-sweep: start at cycle 0, rst in cycle 10
    tick();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (9) tick();
    check("pre-rst busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst state", 32'(st_v[0]), 32'(IDLE));
    check("rst busy", 32'(busy_v[0]), 32'd0);
    check("rst abc", 32'({a_v[0], b_v[0], c_v[0]}), 32'd0);
    check("rst vec_idx", 32'(idx_v[0]), 32'd0);
    check("rst done", 32'(done_v[0]), 32'd0);
    repeat (2) tick();
    check("idle after rst", 32'(st_v[0]), 32'(IDLE));
    run_sweep(0, 2, 1'b1, 8'h00, 1'b0, "post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
